// File: rtl/tbuf_ctrl.sv
// Ping-pong turbo-encoder input buffer: captures index-addressed bits into two banks, streams full banks out in order.
// Build option TBUF_OVF_STICKY_EN: ovf holds until reset instead of pulsing once per dropped write.
module tbuf_ctrl #(
  parameter int AW = 13
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [12:0] m_len,
  input  logic        in_vld,
  input  logic        in_bit,
  input  logic [15:0] idx,
  input  logic        rd_start,
  output logic        dout,
  output logic        dout_vld,
  output logic        dout_last,
  output logic        wr_done,
  output logic [1:0]  full,
  output logic        ovf,
  output logic        rd_busy
);
  typedef enum logic {W_IDLE, W_FILL} wr_st_t;
  typedef enum logic {R_IDLE, R_RUN} rd_st_t;

  wr_st_t wr_st, wr_st_nxt;
  rd_st_t rd_st, rd_st_nxt;

  logic          bank [2][1<<AW];
  logic [12:0]   blen [2];
  logic          wr_bank, rd_bank;
  logic [15:0]   base, off;
  logic [12:0]   len, wcnt, cur_len;
  logic [12:0]   rlen, raddr;
  logic [AW-1:0] waddr;
  logic          we, drop, cmpl;
  logic          start, issue, iss_vld, iss_last, rdq;
  logic [1:0]    full_nxt;

  // Write side: the first accepted bit of a block fixes base and length.
  always_comb begin
    wr_st_nxt = wr_st;
    we        = 1'b0;
    drop      = 1'b0;
    cmpl      = 1'b0;
    waddr     = '0;
    cur_len   = len;
    off       = idx - base;
    if (wr_st == W_IDLE) begin
      cur_len = m_len;
      if (in_vld) begin
        if (full[wr_bank] || m_len == 13'd0) drop = 1'b1;
        else begin
          we = 1'b1;
          if (m_len == 13'd1) cmpl = 1'b1;
          else wr_st_nxt = W_FILL;
        end
      end
    end else if (in_vld) begin
      if (off < {3'b000, len}) begin
        we    = 1'b1;
        waddr = off[AW-1:0];
        if (wcnt + 13'd1 == len) begin
          cmpl      = 1'b1;
          wr_st_nxt = W_IDLE;
        end
      end else drop = 1'b1;
    end
  end

  // A start is refused while the previous block's last beat is still in flight,
  // since rd_bank and its full flag only update on the dout_last edge.
  always_comb begin
    rd_st_nxt = rd_st;
    start     = 1'b0;
    issue     = 1'b0;
    if (rd_st == R_IDLE) begin
      if (rd_start && full[rd_bank] && !iss_last) begin
        start     = 1'b1;
        rd_st_nxt = R_RUN;
      end
    end else begin
      issue = 1'b1;
      if (raddr == rlen - 13'd1) rd_st_nxt = R_IDLE;
    end
  end

  always_comb begin
    full_nxt = full;
    if (cmpl)     full_nxt[wr_bank] = 1'b1;
    if (iss_last) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_st     <= W_IDLE;
      rd_st     <= R_IDLE;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      base      <= '0;
      len       <= '0;
      wcnt      <= '0;
      blen[0]   <= '0;
      blen[1]   <= '0;
      rlen      <= '0;
      raddr     <= '0;
      iss_vld   <= 1'b0;
      iss_last  <= 1'b0;
      dout      <= 1'b0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      wr_done   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      wr_st   <= wr_st_nxt;
      rd_st   <= rd_st_nxt;
      full    <= full_nxt;
      wr_done <= cmpl;
`ifdef TBUF_OVF_STICKY_EN
      ovf     <= ovf | drop;
`else
      ovf     <= drop;
`endif
      if (we) begin
        if (wr_st == W_IDLE) begin
          base <= idx;
          len  <= m_len;
          wcnt <= 13'd1;
        end else wcnt <= wcnt + 13'd1;
      end
      if (cmpl) begin
        blen[wr_bank] <= cur_len;
        wr_bank       <= ~wr_bank;
      end
      if (start) begin
        rlen  <= blen[rd_bank];
        raddr <= '0;
      end else if (issue) raddr <= raddr + 13'd1;
      iss_vld   <= issue;
      iss_last  <= issue && (raddr == rlen - 13'd1);
      dout_vld  <= iss_vld;
      dout_last <= iss_last;
      dout      <= iss_vld & rdq;
      if (iss_last) rd_bank <= ~rd_bank;
    end
  end

  // Bank storage carries no reset; contents are only trusted once written.
  always_ff @(posedge clk) begin
    if (we)    bank[wr_bank][waddr] <= in_bit;
    if (issue) rdq <= bank[rd_bank][raddr[AW-1:0]];
  end

  assign rd_busy = (rd_st == R_RUN);

endmodule

// File: tb/tb_tbuf_ctrl.sv
// Bench for tbuf_ctrl: a block-level model predicts write acceptance and the read-out
// stream; a monitor pops expected beats whenever dout_vld is seen.
`timescale 1ns/1ps
module tb_tbuf_ctrl;
  logic        clk = 1'b0, n_rst = 1'b1;
  logic [12:0] m_len = '0;
  logic        in_vld = 1'b0, in_bit = 1'b0, rd_start = 1'b0;
  logic [15:0] idx = '0;
  logic        dout, dout_vld, dout_last, wr_done, ovf, rd_busy;
  logic [1:0]  full;

  tbuf_ctrl dut (
    .clk(clk), .n_rst(n_rst), .m_len(m_len), .in_vld(in_vld), .in_bit(in_bit),
    .idx(idx), .rd_start(rd_start), .dout(dout), .dout_vld(dout_vld),
    .dout_last(dout_last), .wr_done(wr_done), .full(full), .ovf(ovf), .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit b; bit lst; } beat_t;
  beat_t expq[$];
  int n_chk = 0, n_fail = 0, cyc = 0, start_cyc = 0;
  bit first_pend = 0;

  // reference model: two banks of bits, their lengths and full flags, and the block being filled
  bit m_mem [2][8192];
  int m_blen [2];
  bit m_full [2];
  int m_wb = 0, m_rb = 0, m_base = 0, m_l = 0, m_cnt = 0;
  bit m_fill = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int outs();
    return int'({dout, dout_vld, dout_last, wr_done, ovf, rd_busy, full});
  endfunction

  function automatic int mfull();
    return int'(m_full[1]) * 2 + int'(m_full[0]);
  endfunction

  initial forever begin
    @(negedge clk);
    if (dout_vld) begin
      if (expq.size() == 0) chk("dout_unexpected", 1, 0);
      else begin
        beat_t e;
        e = expq.pop_front();
        chk("dout", int'(dout), int'(e.b));
        chk("dout_last", int'(dout_last), int'(e.lst));
        if (first_pend) begin
          chk("rd_latency", cyc - start_cyc, 2);
          first_pend = 0;
        end
      end
    end else if (dout_last) chk("dout_last_idle", 1, 0);
  end

  task automatic wr(input bit b, input int i, input int ml);
    bit drop, done;
    int off;
    drop = 0; done = 0;
    @(negedge clk);
    in_vld = 1; in_bit = b; idx = i[15:0]; m_len = ml[12:0];
    if (!m_fill) begin
      if (m_full[m_wb] || ml == 0) drop = 1;
      else begin m_fill = 1; m_base = i; m_l = ml; m_cnt = 0; end
    end
    if (m_fill && !drop) begin
      off = (i - m_base) & 32'hffff;
      if (off < m_l) begin
        m_mem[m_wb][off] = b;
        m_cnt++;
        if (m_cnt == m_l) begin
          done = 1; m_full[m_wb] = 1; m_blen[m_wb] = m_l; m_wb ^= 1; m_fill = 0;
        end
      end else drop = 1;
    end
    @(posedge clk); #1;
    chk("wr_done", int'(wr_done), int'(done));
    chk("ovf", int'(ovf), int'(drop));
    in_vld = 0;
  endtask

  task automatic wr_blk(input int base, input int len, input int ml, input bit alt);
    for (int k = 0; k < len; k++) begin
      int i;
      i = (base + k) & 32'hffff;
      wr(alt ? i[0] : 1'($urandom), i, ml);
    end
  endtask

  task automatic rd();
    bit ok;
    int n;
    @(negedge clk);
    ok = m_full[m_rb];
    rd_start = 1;
    if (ok) begin
      for (int k = 0; k < m_blen[m_rb]; k++) begin
        beat_t e;
        e.b = m_mem[m_rb][k];
        e.lst = (k == m_blen[m_rb] - 1);
        expq.push_back(e);
      end
      start_cyc = cyc + 1;
      first_pend = 1;
    end
    @(posedge clk); #1;
    rd_start = 0;
    chk("rd_busy", int'(rd_busy), int'(ok));
    if (ok) begin
      n = 0;
      while ((expq.size() != 0 || dout_vld) && n < 20000) begin
        @(negedge clk); #1;
        n++;
      end
      if (n >= 20000) chk("rd_drain_timeout", 0, 1);
      m_full[m_rb] = 0;
      m_rb ^= 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 0; in_vld = 0; rd_start = 0;
    #2 chk("outs_in_reset", outs(), 0);
    @(negedge clk);
    n_rst = 1;
    m_full[0] = 0; m_full[1] = 0; m_wb = 0; m_rb = 0; m_fill = 0;
    expq.delete(); first_pend = 0;
    @(posedge clk); #1;
    chk("outs_after_reset", outs(), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, %0d of %0d checks failed so far", n_fail, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // alternating 288-bit block, linear index
    wr_blk(0, 288, 288, 1);
    chk("full_t1", int'(full), mfull());
    rd();
    chk("full_t1_rd", int'(full), 0);
    rd();

    // 672-bit random block, then read it while the next block fills the other bank
    wr_blk(288, 672, 672, 0);
    chk("full_t2", int'(full), 2);
    fork
      rd();
      wr_blk(5000, 288, 288, 0);
    join
    chk("full_t2_rd", int'(full), 1);

    // both banks full, third write dropped, oldest block read first
    wr_blk(7000, 288, 288, 0);
    chk("full_t3", int'(full), 3);
    wr(1'b1, 123, 288);
    rd();
    chk("full_t3_rd1", int'(full), 2);
    rd();
    chk("full_t3_rd2", int'(full), 0);

    // out-of-range index mid-fill is dropped without counting
    for (int k = 0; k < 100; k++) wr(1'($urandom), k, 288);
    wr(1'b1, 300, 288);
    for (int k = 100; k < 288; k++) wr(1'($urandom), k, 288);
    chk("full_t4", int'(full), mfull());
    rd();

    // zero length dropped, single-bit block completes at once
    wr(1'b1, 40000, 0);
    wr(1'b1, 40000, 1);
    chk("full_t5", int'(full), mfull());
    rd();
    chk("full_t5_rd", int'(full), 0);

    // reset in the middle of a fill
    for (int k = 0; k < 100; k++) wr(1'($urandom), 500 + k, 288);
    do_reset();
    wr_blk(100, 288, 288, 0);
    chk("full_t6", int'(full), 1);
    rd();

    // random lengths and bases (one wrapping the 16-bit index), with drops and gaps
    for (int blk = 0; blk < 6; blk++) begin
      int len, base;
      len  = $urandom_range(1, 300);
      base = (blk == 2) ? 65535 - 50 : $urandom_range(0, 65535);
      if (m_full[m_wb]) rd();
      for (int k = 0; k < len; k++) begin
        if (k > 0 && $urandom_range(0, 9) == 0)
          wr(1'($urandom), (base + len + $urandom_range(0, 100)) & 32'hffff, len);
        if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        wr(1'($urandom), (base + k) & 32'hffff, len);
      end
      chk("full_rand", int'(full), mfull());
      if ($urandom_range(0, 1) == 1) rd();
    end
    while (m_full[m_rb]) rd();
    chk("full_end", int'(full), 0);
    chk("expq_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
